// File: rtl/cov_pkg.sv
// Shared types and widths for the covariance engine and its divider.
package cov_pkg;
  localparam int Q_W    = 16;  // Q8.8 fixed point
  localparam int PROD_W = 24;
  localparam int ADDR_W = 8;

  typedef enum logic [3:0] {
    IDLE, LD_N, SUM_X, DIV_X, SUM_Y, DIV_Y, ACC_X, ACC_Y, DIV_C, WR_HI, WR_LO, DONE
  } state_t;

  function automatic logic [Q_W-1:0] to_q88(input logic [7:0] b);
    return {b, 8'h00};
  endfunction
endpackage

// File: rtl/cov_divider.sv
// Signed-16 / unsigned-8 floor divider, one quotient bit per cycle on the magnitude.
module cov_divider
  import cov_pkg::*;
(
  input  logic           clk,
  input  logic           srst,
  input  logic           start,
  input  logic [Q_W-1:0] dividend,
  input  logic [7:0]     divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           neg_q, neg_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     rem_q, rem_d;
  logic [7:0]     dsr_q, dsr_d;
  logic [Q_W-1:0] quo_q, quo_d;
  logic [Q_W-1:0] res_q, res_d;
  logic [8:0]     rem_shift;

  always_comb begin
    busy_d    = busy_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    quo_d     = quo_q;
    res_d     = res_q;
    rem_shift = {rem_q, quo_q[Q_W-1]};
    if (busy_q) begin
      if (rem_shift >= {1'b0, dsr_q}) begin
        rem_d = rem_shift[7:0] - dsr_q;
        quo_d = {quo_q[Q_W-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[7:0];
        quo_d = {quo_q[Q_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        // Negative floor: -q when exact, otherwise -q-1 which is ~q.
        res_d  = neg_q ? (~quo_d + Q_W'(~|rem_d)) : quo_d;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = 4'd0;
      rem_d  = 8'd0;
      dsr_d  = divisor;
      neg_d  = dividend[Q_W-1];
      quo_d  = dividend[Q_W-1] ? (~dividend + Q_W'(1)) : dividend;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      res_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      quo_q  <= quo_d;
      res_q  <= res_d;
    end
  end

  assign done     = done_q;
  assign quotient = res_q;
endmodule

// File: rtl/cov_engine.sv
// Covariance engine: means of X and Y, mean of centred products, result written back to memory.
module cov_engine
  import cov_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);
  state_t            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic              issued_q, issued_d;
  logic [7:0]        n_q, n_d, idx_q, idx_d;
  logic [Q_W-1:0]    acc_q, acc_d, x_bar_q, x_bar_d, y_bar_q, y_bar_d, result_q, result_d;
  logic [PROD_W-1:0] dx_q, dx_d, centred;
  logic [Q_W-1:0]    term;
  logic [7:0]        unused_prod_lsb;
  logic              div_start, div_done, wr_en;
  logic [Q_W-1:0]    div_quot;

  // The accumulator doubles as the sum register, so it is always the dividend.
  cov_divider u_div (
    .clk      (Clk),
    .srst     (Reset),
    .start    (div_start),
    .dividend (acc_q),
    .divisor  (n_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign centred = {8'h00, to_q88(mem_rd_data)} - {8'h00, (state_q == ACC_X) ? x_bar_q : y_bar_q};
  assign {term, unused_prod_lsb} = dx_q * centred;
  assign mem_wr_en = wr_en & ~Reset;

  always_comb begin
    state_d      = state_q;
    start_prev_d = Start;
    issued_d     = issued_q;
    n_d          = n_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    x_bar_d      = x_bar_q;
    y_bar_d      = y_bar_q;
    result_d     = result_q;
    dx_d         = dx_q;
    div_start    = 1'b0;
    wr_en        = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    Ack          = 1'b0;
    case (state_q)
      IDLE: if (start_prev_q && !Start) state_d = LD_N;
      LD_N: begin
        n_d      = mem_rd_data;
        idx_d    = 8'd1;
        acc_d    = '0;
        result_d = '0;
        if (mem_rd_data == 8'd0) state_d = WR_HI;
        else                     state_d = SUM_X;
      end
      SUM_X, SUM_Y: begin
        mem_addr = (state_q == SUM_X) ? idx_q : n_q + idx_q;
        acc_d    = acc_q + to_q88(mem_rd_data);
        if (idx_q != n_q)        idx_d   = idx_q + 8'd1;
        else if (state_q == SUM_X) state_d = DIV_X;
        else                     state_d = DIV_Y;
      end
      DIV_X, DIV_Y, DIV_C: begin
        div_start = !issued_q;
        issued_d  = 1'b1;
        if (div_done) begin
          issued_d = 1'b0;
          acc_d    = '0;
          idx_d    = 8'd1;
          if (state_q == DIV_X) begin
            x_bar_d = div_quot;
            state_d = SUM_Y;
          end else if (state_q == DIV_Y) begin
            y_bar_d = div_quot;
            state_d = ACC_X;
          end else begin
            result_d = div_quot;
            state_d  = WR_HI;
          end
        end
      end
      ACC_X: begin
        mem_addr = idx_q;
        dx_d     = centred;
        state_d  = ACC_Y;
      end
      ACC_Y: begin
        mem_addr = n_q + idx_q;
        acc_d    = acc_q + term;
        if (idx_q == n_q) state_d = DIV_C;
        else begin
          idx_d   = idx_q + 8'd1;
          state_d = ACC_X;
        end
      end
      WR_HI: begin
        mem_addr    = {n_q[6:0], 1'b0} + 8'd1;
        mem_wr_data = result_q[15:8];
        wr_en       = 1'b1;
        state_d     = WR_LO;
      end
      WR_LO: begin
        mem_addr    = {n_q[6:0], 1'b0} + 8'd2;
        mem_wr_data = result_q[7:0];
        wr_en       = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        Ack = 1'b1;
        if (Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      issued_q     <= 1'b0;
      n_q          <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      x_bar_q      <= '0;
      y_bar_q      <= '0;
      result_q     <= '0;
      dx_q         <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      issued_q     <= issued_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      x_bar_q      <= x_bar_d;
      y_bar_q      <= y_bar_d;
      result_q     <= result_d;
      dx_q         <= dx_d;
    end
  end
endmodule
